dp_ram_host_sequencer: RTL and testbench
========================================

DP_RAM_HOST_SEQUENCER -- requirements
Module: dp_ram_host_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, the status-poll watchdog limit in clock cycles (used only with HOST_TIMEOUT_EN).
REQ-002 SHALL have ports, in this order:
- CLK  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request one multiply transaction.
- a_in  input  4  operand A.
- b_in  input  4  operand B.
- ADDR  output  4  mailbox word address.
- WRITE_F  output  1  write strobe.
- WRITE_DATA  output  32  write data.
- READ_DATA  input  32  read data; valid one cycle after ADDR is presented with WRITE_F=0.
- BYTE_ENABLE  output  4  byte enables.
- result  output  8  product read back from the peer.
- result_valid  output  1  one-cycle pulse when result is updated.
- busy  output  1  transaction in progress.
- timeout_err  output  1  watchdog abort flag.
- state_o  output  4  current state encoding, for debug.

Function
REQ-003 SHALL act as the host-side initiator of the mailbox protocol: CONTROL=0x0, DATA_IN=0x1, DATA_OUT=0x2, STATUS=0x3.
REQ-004 SHALL hold BYTE_ENABLE at 4'hF at all times.
REQ-005 SHALL decode ADDR, WRITE_F and WRITE_DATA from state only (Moore). Fields not in use SHALL be driven 0, never X.
REQ-006 SHALL have states IDLE(0), WR_DATA(1), WR_CTRL(2), POLL_ADDR(3), POLL_CHK(4), RD_ADDR(5), RD_CAP(6), CLR_CTRL(7), CLR_ADDR(8), CLR_CHK(9), DONE(10), each presented on state_o.
REQ-007 IDLE: ADDR=CONTROL, WRITE_F=0. If start=1, SHALL latch a_in and b_in, then go to WR_DATA. busy=0 only in IDLE.
REQ-008 WR_DATA: ADDR=DATA_IN, WRITE_F=1, WRITE_DATA={24'h0, b_latched, a_latched}; next state WR_CTRL.
REQ-009 WR_CTRL: ADDR=CONTROL, WRITE_F=1, WRITE_DATA=32'h1; next state POLL_ADDR.
REQ-010 POLL_ADDR: ADDR=STATUS, WRITE_F=0; next state POLL_CHK.
REQ-011 POLL_CHK: ADDR=STATUS. If READ_DATA[0]=1, go to RD_ADDR; otherwise go to POLL_ADDR.
REQ-012 RD_ADDR: ADDR=DATA_OUT, WRITE_F=0; next state RD_CAP.
REQ-013 RD_CAP: ADDR=DATA_OUT. SHALL register result<=READ_DATA[7:0] on exit; next state CLR_CTRL.
REQ-014 CLR_CTRL: ADDR=CONTROL, WRITE_F=1, WRITE_DATA=0; next state CLR_ADDR.
REQ-015 CLR_ADDR/CLR_CHK: SHALL poll STATUS as in REQ-010/011 until READ_DATA[0]=0, then go to DONE.
REQ-016 DONE: result_valid=1 for exactly this one cycle; next state IDLE.
REQ-017 start outside IDLE SHALL be ignored. start held high SHALL begin a new transaction on each return to IDLE.
REQ-018 Minimum latency, start sampled to result_valid: 10 cycles, with zero extra poll iterations.
REQ-019 result SHALL hold its value until the next RD_CAP. a_in/b_in changes after the latch SHALL have no effect.
REQ-020 Undefined state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-021 While rst=1: state=IDLE, ADDR=0, WRITE_F=0, WRITE_DATA=0, result=0, result_valid=0, busy=0, timeout_err=0, watchdog counter=0.
REQ-022 Reset mid-transaction SHALL abort immediately with no write strobe and no result_valid. CONTROL SHALL be left as last written. The first post-reset transaction SHALL still complete correctly.

Configuration
REQ-023 Macro HOST_TIMEOUT_EN, when defined:
- A counter SHALL count the cycles spent in POLL_ADDR/POLL_CHK, and separately in CLR_ADDR/CLR_CHK; each count restarts on entry to its loop.
- When a count reaches TIMEOUT_CYCLES, the FSM SHALL go to CLR_CTRL (from the POLL loop) or to IDLE (from the CLR loop), set timeout_err=1 and produce no result_valid.
- timeout_err SHALL clear on the next accepted start.
REQ-024 Without HOST_TIMEOUT_EN: no counter is built, timeout_err is tied to 0, and polling is unbounded.

Verification
REQ-025 a_in=3, b_in=5, start pulse, peer sets STATUS=1 after 4 cycles and writes DATA_OUT=0x0F -> one write of DATA_IN=0x53, one write of CONTROL=1, result=0x0F, one result_valid pulse, CONTROL written to 0.
REQ-026 a=15, b=15, zero-delay peer -> result=0xE1, exactly 10 cycles from start to result_valid.
REQ-027 start pulsed again while in POLL_ADDR -> ignored; exactly one DATA_IN write per transaction.
REQ-028 rst asserted during POLL_CHK -> all outputs at reset values within the same cycle; a following a=2, b=7 transaction -> result=0x0E.
REQ-029 HOST_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, STATUS held at 0 -> timeout_err=1, CONTROL written to 0, FSM back in IDLE, no result_valid.
REQ-030 Peer clears STATUS 6 cycles after CONTROL=0 -> FSM stays in the CLR loop until STATUS=0, then result_valid pulses once.

Source files
------------

// File: rtl/dp_ram_host_sequencer.sv
// Host-side initiator for the mailbox multiply protocol.
// Writes {B,A} to DATA_IN, kicks CONTROL, polls STATUS, reads DATA_OUT,
// clears CONTROL and waits for STATUS to drop before flagging the result.
// Optional status-poll watchdog is enabled by defining HOST_TIMEOUT_EN.
module dp_ram_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  a_in,
  input  logic [3:0]  b_in,
  output logic [3:0]  ADDR,
  output logic        WRITE_F,
  output logic [31:0] WRITE_DATA,
  input  logic [31:0] READ_DATA,
  output logic [3:0]  BYTE_ENABLE,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic [3:0]  state_o
);

  localparam logic [3:0] ADDR_CONTROL  = 4'h0;
  localparam logic [3:0] ADDR_DATA_IN  = 4'h1;
  localparam logic [3:0] ADDR_DATA_OUT = 4'h2;
  localparam logic [3:0] ADDR_STATUS   = 4'h3;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_DATA   = 4'd1,
    WR_CTRL   = 4'd2,
    POLL_ADDR = 4'd3,
    POLL_CHK  = 4'd4,
    RD_ADDR   = 4'd5,
    RD_CAP    = 4'd6,
    CLR_CTRL  = 4'd7,
    CLR_ADDR  = 4'd8,
    CLR_CHK   = 4'd9,
    DONE      = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] result_q, result_d;
  logic       wd_expired;
  logic       aborted;
  logic       unused_bits;

`ifdef HOST_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            in_poll_loop;

  // The counter is held at zero outside the two poll loops, so it restarts
  // on every loop entry; the two loops are never adjacent.
  assign in_poll_loop = (state_q == POLL_ADDR) || (state_q == POLL_CHK) ||
                        (state_q == CLR_ADDR)  || (state_q == CLR_CHK);
  assign wd_expired   = in_poll_loop && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign aborted      = timeout_q;
  assign timeout_err  = timeout_q;
  assign unused_bits  = ^READ_DATA[31:8];

  // Watchdog count and abort-flag next state
  always_comb begin
    wd_d      = '0;
    timeout_d = timeout_q;
    if (in_poll_loop) begin
      wd_d = wd_q + 1'b1;
    end
    if ((state_q == IDLE) && start) begin
      timeout_d = 1'b0;
    end else if (wd_expired) begin
      timeout_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign aborted     = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_bits = ^{READ_DATA[31:8], (TIMEOUT_CYCLES != 0)};
`endif

  // Next-state, operand latch and result capture
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = WR_DATA;
        end
      end
      WR_DATA:   state_d = WR_CTRL;
      WR_CTRL:   state_d = POLL_ADDR;
      POLL_ADDR: state_d = wd_expired ? CLR_CTRL : POLL_CHK;
      POLL_CHK: begin
        if (wd_expired)        state_d = CLR_CTRL;
        else if (READ_DATA[0]) state_d = RD_ADDR;
        else                   state_d = POLL_ADDR;
      end
      RD_ADDR:   state_d = RD_CAP;
      RD_CAP: begin
        result_d = READ_DATA[7:0];
        state_d  = CLR_CTRL;
      end
      CLR_CTRL:  state_d = CLR_ADDR;
      CLR_ADDR:  state_d = wd_expired ? IDLE : CLR_CHK;
      CLR_CHK: begin
        // An aborted transaction drains the clear handshake silently.
        if (wd_expired)         state_d = IDLE;
        else if (!READ_DATA[0]) state_d = aborted ? IDLE : DONE;
        else                    state_d = CLR_ADDR;
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Moore bus decode from the current state
  always_comb begin
    ADDR       = '0;
    WRITE_F    = 1'b0;
    WRITE_DATA = '0;
    case (state_q)
      IDLE:      ADDR = ADDR_CONTROL;
      WR_DATA: begin
        ADDR       = ADDR_DATA_IN;
        WRITE_F    = 1'b1;
        WRITE_DATA = {24'h0, b_q, a_q};
      end
      WR_CTRL: begin
        ADDR       = ADDR_CONTROL;
        WRITE_F    = 1'b1;
        WRITE_DATA = 32'h1;
      end
      POLL_ADDR: ADDR = ADDR_STATUS;
      POLL_CHK:  ADDR = ADDR_STATUS;
      RD_ADDR:   ADDR = ADDR_DATA_OUT;
      RD_CAP:    ADDR = ADDR_DATA_OUT;
      CLR_CTRL: begin
        ADDR       = ADDR_CONTROL;
        WRITE_F    = 1'b1;
        WRITE_DATA = '0;
      end
      CLR_ADDR:  ADDR = ADDR_STATUS;
      CLR_CHK:   ADDR = ADDR_STATUS;
      default:   ADDR = '0;
    endcase
  end

  assign BYTE_ENABLE  = 4'hF;
  assign result       = result_q;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_dp_ram_host_sequencer.sv
// Self-checking bench: a mailbox peer with programmable STATUS delays,
// a write/pulse monitor, table-driven and randomized transactions checked
// against arithmetic expectations (product, bus writes, poll latency).
module tb_dp_ram_host_sequencer;

  logic        CLK = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  a_in, b_in;
  logic [3:0]  ADDR;
  logic        WRITE_F;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA = '0;
  logic [3:0]  BYTE_ENABLE;
  logic [7:0]  result;
  logic        result_valid;
  logic        busy;
  logic        timeout_err;
  logic [3:0]  state_o;

  dp_ram_host_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .ADDR(ADDR), .WRITE_F(WRITE_F), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA), .BYTE_ENABLE(BYTE_ENABLE), .result(result),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err),
    .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- mailbox peer ----------------
  logic [31:0] mbox [4] = '{default: '0};
  int peer_sd = 0;   // cycles from CONTROL=1 write to STATUS=1; -1 = never
  int peer_cd = 0;   // cycles from CONTROL=0 write to STATUS=0
  int set_cnt = 0;
  int clr_cnt = 0;

  function automatic logic [31:0] prod(input logic [31:0] d);
    logic [7:0] p;
    p = {4'h0, d[3:0]} * {4'h0, d[7:4]};
    return {24'h0, p};
  endfunction

  always @(posedge CLK) begin
    READ_DATA <= (ADDR < 4'd4) ? mbox[ADDR[1:0]] : '0;
    if (set_cnt > 0) begin
      set_cnt <= set_cnt - 1;
      if (set_cnt == 1) begin
        mbox[3] <= 32'h1;
        mbox[2] <= prod(mbox[1]);
      end
    end
    if (clr_cnt > 0) begin
      clr_cnt <= clr_cnt - 1;
      if (clr_cnt == 1) mbox[3] <= 32'h0;
    end
    if (WRITE_F && (ADDR < 4'd4)) begin
      mbox[ADDR[1:0]] <= WRITE_DATA;
      if (ADDR == 4'h0) begin
        set_cnt <= 0;
        clr_cnt <= 0;
        if (WRITE_DATA[0]) begin
          if (peer_sd == 0) begin
            mbox[3] <= 32'h1;
            mbox[2] <= prod(mbox[1]);
          end else begin
            mbox[3] <= 32'h0;
            if (peer_sd > 0) set_cnt <= peer_sd;
          end
        end else begin
          if (peer_cd == 0) mbox[3] <= 32'h0;
          else              clr_cnt <= peer_cd;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [35:0] wr_q [$];
  int rv_cnt = 0;

  always @(negedge CLK) begin
    if (!rst) begin
      if (WRITE_F) wr_q.push_back({ADDR, WRITE_DATA});
      if (result_valid) rv_cnt <= rv_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  // Each poll iteration costs two cycles; STATUS changing d cycles after
  // the control write is seen after ceil(d/2) extra iterations.
  function automatic int exp_lat(input int sd, input int cd);
    return 10 + 2 * ((sd + 1) / 2) + 2 * ((cd + 1) / 2);
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (busy && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 500) check("idle_wait_bound", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ADDR"}, ADDR, 4'h0);
    check({tag, "_WRITE_F"}, WRITE_F, 1'b0);
    check({tag, "_WRITE_DATA"}, WRITE_DATA, 32'h0);
    check({tag, "_result"}, result, 8'h00);
    check({tag, "_result_valid"}, result_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
    check({tag, "_state"}, state_o, 4'd0);
  endtask

  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int sd,
                         input int cd, input bit rep, input logic [7:0] exp_res);
    int lat;
    bit got;
    bit pulsed;
    int rv0;
    logic [35:0] expw [3];
    wait_idle();
    peer_sd = sd;
    peer_cd = cd;
    wr_q.delete();
    rv0 = rv_cnt;
    expw[0] = {4'h1, 24'h0, b, a};
    expw[1] = {4'h0, 32'h1};
    expw[2] = {4'h0, 32'h0};
    a_in = a; b_in = b; start = 1'b1;
    lat = 0; got = 1'b0; pulsed = 1'b0;
    while (!got && lat < 300) begin
      @(negedge CLK);
      lat++;
      start = 1'b0;
      if (lat == 1) begin
        a_in = 4'($urandom);
        b_in = 4'($urandom);
      end
      if (rep && !pulsed && state_o == 4'd3) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (result_valid) got = 1'b1;
    end
    check("rv_seen", got, 1'b1);
    check("latency", lat, exp_lat(sd, cd));
    check("result", result, exp_res);
    @(negedge CLK);
    check("rv_one_cycle", result_valid, 1'b0);
    check("result_hold", result, exp_res);
    check("rv_count", rv_cnt - rv0, 1);
    check("byte_enable", BYTE_ENABLE, 4'hF);
    check("n_writes", wr_q.size(), 3);
    for (int i = 0; i < 3 && i < wr_q.size(); i++)
      check($sformatf("write%0d", i), wr_q[i][31:0] ^ {28'h0, wr_q[i][35:32]},
            expw[i][31:0] ^ {28'h0, expw[i][35:32]});
    for (int i = 0; i < 3 && i < wr_q.size(); i++)
      check($sformatf("write%0d_addr", i), wr_q[i][35:32], expw[i][35:32]);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         sd;
    int         cd;
    bit         rep;
    logic [7:0] exp_res;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n;
    int rv0;
    logic [3:0] ra, rb;

    tbl[0] = '{a: 4'd3,  b: 4'd5,  sd: 4, cd: 0, rep: 1'b0, exp_res: 8'h0F};
    tbl[1] = '{a: 4'd15, b: 4'd15, sd: 0, cd: 0, rep: 1'b0, exp_res: 8'hE1};
    tbl[2] = '{a: 4'd0,  b: 4'd9,  sd: 1, cd: 1, rep: 1'b0, exp_res: 8'h00};
    tbl[3] = '{a: 4'd7,  b: 4'd8,  sd: 2, cd: 6, rep: 1'b0, exp_res: 8'h38};
    tbl[4] = '{a: 4'd12, b: 4'd11, sd: 0, cd: 6, rep: 1'b0, exp_res: 8'h84};
    tbl[5] = '{a: 4'd6,  b: 4'd13, sd: 3, cd: 2, rep: 1'b1, exp_res: 8'h4E};
    tbl[6] = '{a: 4'd1,  b: 4'd15, sd: 5, cd: 0, rep: 1'b1, exp_res: 8'h0F};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst");
    check("rst_byte_enable", BYTE_ENABLE, 4'hF);
    rst = 1'b0;

    foreach (tbl[i])
      run_txn(tbl[i].a, tbl[i].b, tbl[i].sd, tbl[i].cd, tbl[i].rep, tbl[i].exp_res);

    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_txn(ra, rb, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)), {4'h0, ra} * {4'h0, rb});
    end

    // start held high: a new transaction begins on the return to IDLE
    wait_idle();
    peer_sd = 0; peer_cd = 0;
    a_in = 4'd1; b_in = 4'd2; start = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!result_valid && n < 100);
    check("held_rv1", result_valid, 1'b1);
    check("held_res1", result, 8'h02);
    @(negedge CLK);
    check("held_idle", state_o, 4'd0);
    a_in = 4'd4; b_in = 4'd3;
    @(negedge CLK);
    check("held_restart", state_o, 4'd1);
    check("held_wdata", WRITE_DATA, 32'h34);
    start = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!result_valid && n < 100);
    check("held_rv2", result_valid, 1'b1);
    check("held_res2", result, 8'h0C);

    // reset in POLL_CHK aborts at once, CONTROL keeps its last value
    wait_idle();
    peer_sd = 10; peer_cd = 0;
    rv0 = rv_cnt;
    a_in = 4'd9; b_in = 4'd9; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (state_o != 4'd4 && n < 50) begin @(negedge CLK); n++; end
    check("reach_poll_chk", state_o, 4'd4);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge CLK);
    check("midrst_wf_held", WRITE_F, 1'b0);
    rst = 1'b0;
    check("control_kept", mbox[0], 32'h1);
    check("midrst_no_rv", rv_cnt - rv0, 0);
    run_txn(4'd2, 4'd7, 0, 0, 1'b0, 8'h0E);

`ifdef HOST_TIMEOUT_EN
    // STATUS never rises: watchdog aborts through the clear handshake
    wait_idle();
    peer_sd = -1; peer_cd = 0;
    wr_q.delete();
    rv0 = rv_cnt;
    a_in = 4'd5; b_in = 4'd5; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(negedge CLK); n++; end
    check("to_back_idle", state_o, 4'd0);
    check("to_flag", timeout_err, 1'b1);
    @(negedge CLK);
    check("to_no_rv", rv_cnt - rv0, 0);
    check("to_ctrl_cleared", mbox[0], 32'h0);
    check("to_n_writes", wr_q.size(), 3);
    if (wr_q.size() > 0) check("to_last_write", wr_q[wr_q.size()-1], 36'h0_0000_0000);
    check("to_result_kept", result, 8'h0E);
    run_txn(4'd4, 4'd4, 0, 0, 1'b0, 8'h10);
    check("to_flag_cleared", timeout_err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_vec);
    $fatal(1, "global time limit");
  end

endmodule
